idelay_tap_scanner: RTL and testbench

- Sweeps an IDELAYE2 in VAR_LOAD mode through every tap value.
- At each tap it loads the tap, waits for the delay to settle, reads back CNTVALUEOUT, and samples the delayed data against a free-running phase reference.
- It reports a per-tap result stream and the first tap where the sampled phase flips, which is the data-eye edge.
- It sits between the idelay_calibrator ready flag and the IDELAYE2 LD/CNTVALUEIN/CNTVALUEOUT/DATAOUT pins, replacing manual button stepping.

---
 rtl/idelay_pkg.sv | 23 ++
 rtl/idelay_phase_sampler.sv | 62 ++++++
 rtl/idelay_tap_scanner.sv | 152 +++++++++++++++
 tb/tb_idelay_tap_scanner.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/idelay_pkg.sv
// idelay_pkg: constants and FSM encoding shared by the IDELAYE2 calibration and scan blocks.
package idelay_pkg;

    // IDELAYE2 tap field width and tap count
    localparam int TAP_W    = 5;
    localparam int MAX_TAPS = 32;

    // Scan FSM encoding
    typedef logic [2:0] scan_state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_SETTLE = 3'd2;
    localparam logic [2:0] ST_SAMPLE = 3'd3;
    localparam logic [2:0] ST_REPORT = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    // True in the states where a scan owns the delay line and must abort if calibration is lost
    function automatic logic is_scan_state(input logic [2:0] st);
        return (st == ST_LOAD) || (st == ST_SETTLE) || (st == ST_SAMPLE) || (st == ST_REPORT);
    endfunction

endpackage

// File: rtl/idelay_phase_sampler.sv
// idelay_phase_sampler: registers the delayed data, compares it against a free-running
// phase reference and accumulates how often the two disagree over one sample window.
module idelay_phase_sampler
    import idelay_pkg::*;
#(
    parameter int SAMPLE_LOG2 = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   din,
    input  logic                   smp_en,
    input  logic [SAMPLE_LOG2:0]   cls_cnt,
    output logic                   smp_last,
    output logic [SAMPLE_LOG2:0]   smp_cnt_nxt,
    output logic                   cls_hi
);

    localparam int CNT_W = SAMPLE_LOG2 + 1;
    localparam logic [CNT_W-1:0] HALF = CNT_W'(2 ** (SAMPLE_LOG2 - 1));

    logic                   din_q;
    logic                   p;
    logic                   s;
    logic [SAMPLE_LOG2-1:0] smp_idx;
    logic [CNT_W-1:0]       smp_acc;

    // A window count at or above half the window means the data leads the reference phase
    function automatic logic phase_class(input logic [CNT_W-1:0] cnt);
        return (cnt >= HALF);
    endfunction

    assign s           = din_q ^ p;
    assign smp_cnt_nxt = smp_acc + CNT_W'(s);
    assign smp_last    = (smp_idx == '1);
    assign cls_hi      = phase_class(cls_cnt);

    // Capture the delayed data and run the toggling phase reference
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            din_q <= 1'b0;
            p     <= 1'b0;
        end else begin
            din_q <= din;
            p     <= ~p;
        end
    end

    // Accumulate sample bits over the window; hold cleared whenever not sampling
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp_idx <= '0;
            smp_acc <= '0;
        end else if (!smp_en) begin
            smp_idx <= '0;
            smp_acc <= '0;
        end else begin
            smp_idx <= smp_idx + SAMPLE_LOG2'(1);
            smp_acc <= smp_cnt_nxt;
        end
    end

endmodule

// File: rtl/idelay_tap_scanner.sv
// idelay_tap_scanner: steps an IDELAYE2 (VAR_LOAD) through every tap, checks the tap
// readback, reports a per-tap phase count and records the first tap where the phase flips.
module idelay_tap_scanner
    import idelay_pkg::*;
#(
    parameter int NUM_TAPS      = 32,
    parameter int SETTLE_CYCLES = 16,
    parameter int SAMPLE_LOG2   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cal_rdy,
    input  logic                   start,
    output logic                   dly_ld,
    output logic [TAP_W-1:0]       dly_cntvaluein,
    input  logic [TAP_W-1:0]       dly_cntvalueout,
    input  logic                   din,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic                   res_valid,
    output logic [TAP_W-1:0]       res_tap,
    output logic [SAMPLE_LOG2:0]   res_count,
    output logic                   edge_found,
    output logic [TAP_W-1:0]       edge_tap
);

    localparam int CNT_W = SAMPLE_LOG2 + 1;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [TAP_W-1:0] LAST_TAP    = TAP_W'(NUM_TAPS - 1);
    localparam logic [SET_W-1:0] LAST_SETTLE = SET_W'(SETTLE_CYCLES - 1);

    scan_state_t       state;
    logic [TAP_W-1:0]  tap;
    logic [SET_W-1:0]  settle_cnt;
    logic              cls0;
    logic              smp_en;
    logic              smp_last;
    logic              smp_done;
    logic              cls_hi;
    logic              scan_abort;
    logic [CNT_W-1:0]  smp_cnt_nxt;

    assign smp_en         = (state == ST_SAMPLE);
    assign smp_done       = smp_en && smp_last && cal_rdy;
    assign scan_abort     = is_scan_state(state) && !cal_rdy;
    assign dly_ld         = (state == ST_LOAD);
    assign dly_cntvaluein = tap;

    idelay_phase_sampler #(
        .SAMPLE_LOG2 (SAMPLE_LOG2)
    ) u_sampler (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .smp_en      (smp_en),
        .cls_cnt     (res_count),
        .smp_last    (smp_last),
        .smp_cnt_nxt (smp_cnt_nxt),
        .cls_hi      (cls_hi)
    );

    // Scan sequencing, readback check and edge search; loss of calibration aborts at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            tap        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            edge_found <= 1'b0;
            edge_tap   <= '0;
            cls0       <= 1'b0;
        end else if (scan_abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && cal_rdy) begin
                        tap        <= '0;
                        err        <= 1'b0;
                        edge_found <= 1'b0;
                        edge_tap   <= '0;
                        done       <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    settle_cnt <= '0;
                    state      <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (settle_cnt == LAST_SETTLE) begin
                        state <= ST_SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (smp_last) begin
                        state <= ST_REPORT;
                    end
                end
                ST_REPORT: begin
                    if (dly_cntvalueout != tap) begin
                        err <= 1'b1;
                    end
                    // Tap 0 defines the reference class; only the first differing tap is kept
                    if (tap == '0) begin
                        cls0 <= cls_hi;
                    end else if (!edge_found && (cls_hi != cls0)) begin
                        edge_found <= 1'b1;
                        edge_tap   <= tap;
                    end
                    if (tap == LAST_TAP) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        tap   <= tap + TAP_W'(1);
                        state <= ST_LOAD;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-tap result: valid for exactly the REPORT cycle, values held afterwards
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_tap   <= '0;
            res_count <= '0;
        end else begin
            res_valid <= smp_done;
            if (smp_done) begin
                res_tap   <= tap;
                res_count <= smp_cnt_nxt;
            end
        end
    end

endmodule

// File: tb/tb_idelay_tap_scanner.sv
// tb_idelay_tap_scanner: randomized scans against a tap-level reference model with a
// scoreboard of per-tap results drained by an independent monitor.
module tb_idelay_tap_scanner;

    localparam int NUM_TAPS = 32;
    localparam int SETTLE   = 4;
    localparam int LOG2     = 4;
    localparam int FULL     = 2 ** LOG2;
    localparam int HALF     = 2 ** (LOG2 - 1);
    localparam int TAP_LAT  = 2 + SETTLE + FULL;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           cal_rdy = 1'b0;
    logic           start = 1'b0;
    logic           dly_ld;
    logic [4:0]     dly_cntvaluein;
    logic [4:0]     dly_cntvalueout = 5'd0;
    logic           din = 1'b0;
    logic           busy, done, err, res_valid, edge_found;
    logic [4:0]     res_tap, edge_tap;
    logic [LOG2:0]  res_count;

    typedef struct {
        int tap;
        int cnt;
        int errb;
    } exp_t;

    exp_t        sb[$];
    int          vectors = 0;
    int          miscompares = 0;
    int          n_res = 0;
    int unsigned cyc = 0;

    // Delay-line environment: per-tap phase behaviour and readback mode
    int          modes[NUM_TAPS];
    bit          stuck = 1'b0;
    logic        tb_p = 1'b0;
    logic [4:0]  ld_tap = 5'd0;

    idelay_tap_scanner #(
        .NUM_TAPS      (NUM_TAPS),
        .SETTLE_CYCLES (SETTLE),
        .SAMPLE_LOG2   (LOG2)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cal_rdy         (cal_rdy),
        .start           (start),
        .dly_ld          (dly_ld),
        .dly_cntvaluein  (dly_cntvaluein),
        .dly_cntvalueout (dly_cntvalueout),
        .din             (din),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .res_valid       (res_valid),
        .res_tap         (res_tap),
        .res_count       (res_count),
        .edge_found      (edge_found),
        .edge_tap        (edge_tap)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // IDELAYE2 model: LD captures CNTVALUEIN on the clock; reference phase bit tracked from reset
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tb_p   <= 1'b0;
            ld_tap <= 5'd0;
        end else begin
            if (dly_ld) ld_tap <= dly_cntvaluein;
            tb_p <= ~tb_p;
        end
    end

    // Data source: mode 0 keeps s=0, mode 1 keeps s=1, mode 2 holds din low
    always @(negedge clk) begin
        if (modes[ld_tap] == 2) din <= 1'b0;
        else                    din <= (modes[ld_tap] == 1) ^ ~tb_p;
        dly_cntvalueout <= stuck ? 5'd0 : ld_tap;
    end

    function automatic int mode_cnt(input int m);
        if (m == 0) return 0;
        if (m == 1) return FULL;
        return HALF;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every result pulse is matched against the head of the scoreboard
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && res_valid) begin
                n_res++;
                if (sb.size() == 0) begin
                    check("unexpected_result_tap", res_tap, -1);
                end else begin
                    e = sb.pop_front();
                    check("res_tap", res_tap, e.tap);
                    check("res_count", res_count, e.cnt);
                    check("err_before_report", err, e.errb);
                end
            end
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {dly_ld, busy, done, err, res_valid, edge_found}, 0);
        check({tag, "_cntvaluein"}, dly_cntvaluein, 0);
        check({tag, "_res_tap"}, res_tap, 0);
        check({tag, "_res_count"}, res_count, 0);
        check({tag, "_edge_tap"}, edge_tap, 0);
    endtask

    task automatic randomize_modes();
        for (int k = 0; k < NUM_TAPS; k++) modes[k] = int'($urandom_range(0, 2));
    endtask

    // One scan: abort_tap / rst_tap >= 1 interrupts during SAMPLE of that tap
    task automatic run_scan(input bit stk, input int abort_tap, input int rst_tap, input bit spam);
        int  n_exp, t0, mark, tgt;
        bit  got, cls0, efound;
        int  etap;
        repeat (3) @(negedge clk);
        stuck = stk;
        sb.delete();
        n_res = 0;
        tgt   = (abort_tap >= 0) ? abort_tap : rst_tap;
        n_exp = (tgt >= 0) ? tgt : NUM_TAPS;
        for (int k = 0; k < NUM_TAPS; k++)
            sb.push_back('{k, mode_cnt(modes[k]), int'(stk && k >= 2)});
        efound = 1'b0;
        etap   = 0;
        cls0   = mode_cnt(modes[0]) >= HALF;
        for (int k = 1; k < n_exp; k++)
            if (!efound && ((mode_cnt(modes[k]) >= HALF) != cls0)) begin
                efound = 1'b1;
                etap   = k;
            end

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            if (dly_ld && dly_cntvaluein == 5'd0) got = 1'b1;
            else @(negedge clk);
        end
        check("load_tap0_seen", got, 1);
        if (!got) return;
        t0 = int'(cyc);
        check("busy_at_start", busy, 1);
        check("start_clears_err", err, 0);
        check("start_clears_done", done, 0);
        check("start_clears_edge", edge_found, 0);

        got  = 1'b0;
        mark = -1;
        for (int i = 0; i < 2 * NUM_TAPS * TAP_LAT && !got; i++) begin
            @(negedge clk);
            start = spam && ($urandom_range(0, 15) == 0);
            if (tgt >= 0) begin
                if (res_valid && res_tap == 5'(tgt - 1)) mark = int'(cyc);
                if (mark >= 0 && int'(cyc) == mark + 2 + SETTLE + 4) got = 1'b1;
            end else if (done) begin
                got = 1'b1;
            end
        end
        start = 1'b0;
        check("scan_event_within_budget", got, 1);
        if (!got) return;

        if (abort_tap >= 0) begin
            cal_rdy = 1'b0;
            @(negedge clk);
            check("abort_busy", busy, 0);
            check("abort_done", done, 0);
            check("abort_dly_ld", dly_ld, 0);
            check("abort_err", err, int'(stk && n_exp >= 2));
            check("abort_edge_found", edge_found, efound);
            check("abort_edge_tap", edge_tap, etap);
            check("abort_result_count", n_res, n_exp);
            cal_rdy = 1'b1;
            sb.delete();
        end else if (rst_tap >= 0) begin
            #2 rst = 1'b1;
            #1 check_all_zero("async_rst_in_sample");
            @(negedge clk);
            rst = 1'b0;
            sb.delete();
        end else begin
            check("scan_latency", int'(cyc) - t0, NUM_TAPS * TAP_LAT);
            check("done_busy", busy, 0);
            check("done_err", err, int'(stk));
            check("done_edge_found", edge_found, efound);
            check("done_edge_tap", edge_tap, etap);
            check("done_result_count", n_res, NUM_TAPS);
            check("done_sb_empty", sb.size(), 0);
            check("done_res_tap_held", res_tap, NUM_TAPS - 1);
            @(negedge clk);
            check("done_held", done, 1);
        end
    endtask

    initial begin
        for (int k = 0; k < NUM_TAPS; k++) modes[k] = 0;

        // Asynchronous reset asserted between clock edges
        #12 rst = 1'b1;
        #1 check_all_zero("reset");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // start without calibration must be ignored
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("nocal_busy", busy, 0);
            check("nocal_dly_ld", dly_ld, 0);
        end
        cal_rdy = 1'b1;

        // Phase flips at tap 12
        for (int k = 0; k < NUM_TAPS; k++) modes[k] = (k < 12) ? 0 : 1;
        run_scan(1'b0, -1, -1, 1'b0);

        // din held low: every count at half window, no edge
        for (int k = 0; k < NUM_TAPS; k++) modes[k] = 2;
        run_scan(1'b0, -1, -1, 1'b0);

        // Readback stuck at zero
        randomize_modes();
        run_scan(1'b1, -1, -1, 1'b0);

        // Fresh start clears err; start pulses during the scan are ignored
        randomize_modes();
        run_scan(1'b0, -1, -1, 1'b1);

        // Calibration lost during SAMPLE of tap 5
        randomize_modes();
        run_scan(1'b0, 5, -1, 1'b0);

        // Async reset during SAMPLE of tap 9, then a clean full scan
        randomize_modes();
        run_scan(1'b0, -1, 9, 1'b0);
        randomize_modes();
        run_scan(1'b0, -1, -1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
